// File: rtl/draw_player.sv
// Player overlay: draws the player square over the background stream and moves it once per frame.
// Build option: define DRAW_PLAYER_COLLISION_EN to enable the obstacle tests; without it only screen bounds apply.
module draw_player #(
  parameter int          PLAYER_SIZE = 20,
  parameter int          STEP        = 4,
  parameter int          START_X     = 20,
  parameter int          START_Y     = 500,
  parameter logic [11:0] PLAYER_RGB  = 12'h0F0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblank_in,
  input  logic        vsync_in,
  input  logic        vblank_in,
  input  logic [11:0] rgb_in,
  input  logic [17:0] st_obst_xy,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblank_out,
  output logic        vsync_out,
  output logic        vblank_out,
  output logic [11:0] rgb_out,
  output logic [10:0] player_x,
  output logic [10:0] player_y,
  output logic        at_door
);

  localparam logic [11:0] SZ = 12'(PLAYER_SIZE);
  localparam logic [11:0] ST = 12'(STEP);

  typedef enum logic [2:0] {IDLE, CHK_X, CHK_Y, COMMIT, WON} state_t;

  state_t      state_q, state_d;
  logic        vblank_prev_q, vblank_prev_d;
  logic [1:0]  idx_q, idx_d;
  logic        up_q, up_d, down_q, down_d;
  logic        ok_q, ok_d;
  logic [11:0] cx_q, cx_d, cy_q, cy_d;
  logic [10:0] player_x_q, player_x_d, player_y_q, player_y_d;

  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_q, hsync_d, hblank_q, hblank_d;
  logic        vsync_q, vsync_d, vblank_q, vblank_d;
  logic [11:0] rgb_q, rgb_d;

  logic [11:0] x_wide, y_wide, h_wide, v_wide;
  logic        in_box;
  logic        hit;

  assign x_wide = {1'b0, player_x_q};
  assign y_wide = {1'b0, player_y_q};
  assign h_wide = {1'b0, hcount_in};
  assign v_wide = {1'b0, vcount_in};

`ifdef DRAW_PLAYER_COLLISION_EN
  logic [2:0]  ob_x, ob_y;
  logic [11:0] ob_left, ob_top, ty;

  // One obstacle per check cycle; CHK_X tests against the committed y, CHK_Y against the candidate y.
  always_comb begin
    ob_x = 3'd0;
    ob_y = 3'd0;
    case (idx_q)
      2'd0: begin ob_x = st_obst_xy[17:15]; ob_y = st_obst_xy[14:12]; end
      2'd1: begin ob_x = st_obst_xy[11:9];  ob_y = st_obst_xy[8:6];   end
      2'd2: begin ob_x = st_obst_xy[5:3];   ob_y = st_obst_xy[2:0];   end
      default: ;
    endcase
    ob_left = 12'(ob_x) * 12'd100;
    ob_top  = 12'(ob_y) * 12'd100;
    ty      = (state_q == CHK_Y) ? cy_q : y_wide;
    hit     = (idx_q != 2'd3) &&
              (cx_q < ob_left + 12'd100) && (cx_q + SZ > ob_left) &&
              (ty < ob_top + 12'd100) && (ty + SZ > ob_top);
  end
`else
  logic unused_obst;
  assign unused_obst = ^st_obst_xy;
  assign hit = 1'b0;
`endif

  always_comb begin
    hcount_d = hcount_in;
    vcount_d = vcount_in;
    hsync_d  = hsync_in;
    hblank_d = hblank_in;
    vsync_d  = vsync_in;
    vblank_d = vblank_in;
    in_box   = (h_wide >= x_wide) && (h_wide < x_wide + SZ) &&
               (v_wide >= y_wide) && (v_wide < y_wide + SZ);
    rgb_d    = (!hblank_in && !vblank_in && in_box) ? PLAYER_RGB : rgb_in;
  end

  always_comb begin
    state_d       = state_q;
    vblank_prev_d = vblank_in;
    idx_d         = idx_q;
    up_d          = up_q;
    down_d        = down_q;
    ok_d          = ok_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    player_x_d    = player_x_q;
    player_y_d    = player_y_q;
    case (state_q)
      IDLE: begin
        if (vblank_in && !vblank_prev_q) begin
          // Buttons are latched here so later changes cannot affect this frame's move.
          up_d    = btn_up && !btn_down;
          down_d  = btn_down && !btn_up;
          idx_d   = 2'd0;
          state_d = CHK_X;
          if (btn_right && !btn_left) begin
            cx_d = x_wide + ST;
            ok_d = (cx_d <= 12'd799 - SZ);
          end else if (btn_left && !btn_right) begin
            cx_d = x_wide - ST;
            ok_d = (x_wide >= 12'd1 + ST);
          end else begin
            cx_d = x_wide;
            ok_d = 1'b1;
          end
        end
      end
      CHK_X: begin
        ok_d  = ok_q && !hit;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd2) begin
          idx_d   = 2'd0;
          state_d = CHK_Y;
          if (!(ok_q && !hit)) cx_d = x_wide;
          if (down_q) begin
            cy_d = y_wide + ST;
            ok_d = (cy_d <= 12'd599 - SZ);
          end else if (up_q) begin
            cy_d = y_wide - ST;
            ok_d = (y_wide >= 12'd1 + ST);
          end else begin
            cy_d = y_wide;
            ok_d = 1'b1;
          end
        end
      end
      CHK_Y: begin
        ok_d  = ok_q && !hit;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd2) begin
          idx_d   = 2'd0;
          state_d = COMMIT;
          if (!(ok_q && !hit)) cy_d = y_wide;
        end
      end
      COMMIT: begin
        player_x_d = cx_q[10:0];
        player_y_d = cy_q[10:0];
        if ((cx_q >= 12'd710) && (cx_q + SZ <= 12'd790) &&
            (cy_q >= 12'd250) && (cy_q + SZ <= 12'd390))
          state_d = WON;
        else
          state_d = IDLE;
      end
      WON: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= IDLE;
      vblank_prev_q <= 1'b0;
      idx_q         <= 2'd0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      ok_q          <= 1'b0;
      cx_q          <= 12'd0;
      cy_q          <= 12'd0;
      player_x_q    <= 11'(START_X);
      player_y_q    <= 11'(START_Y);
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      rgb_q         <= 12'd0;
    end else begin
      state_q       <= state_d;
      vblank_prev_q <= vblank_prev_d;
      idx_q         <= idx_d;
      up_q          <= up_d;
      down_q        <= down_d;
      ok_q          <= ok_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      player_x_q    <= player_x_d;
      player_y_q    <= player_y_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblank_q      <= hblank_d;
      vsync_q       <= vsync_d;
      vblank_q      <= vblank_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign hblank_out = hblank_q;
  assign vsync_out  = vsync_q;
  assign vblank_out = vblank_q;
  assign rgb_out    = rgb_q;
  assign player_x   = player_x_q;
  assign player_y   = player_y_q;
  assign at_door    = (state_q == WON);

endmodule

// File: doc/draw_player.md
DRAW_PLAYER -- requirements
Module: draw_player

Interface
REQ-001 Parameter PLAYER_SIZE, default 20, player square side in pixels.
REQ-002 Parameter STEP, default 4, pixels moved per frame per axis.
REQ-003 Parameter START_X, default 20, reset x of player top-left corner.
REQ-004 Parameter START_Y, default 500, reset y of player top-left corner.
REQ-005 Parameter PLAYER_RGB, default 12'h0F0, player fill colour.
REQ-006 pclk  in  1  pixel clock, all state on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 hcount_in, vcount_in  in  11 each  pixel counters from background stage.
REQ-009 hsync_in, hblank_in, vsync_in, vblank_in  in  1 each  timing from background stage.
REQ-010 rgb_in  in  12  background pixel colour.
REQ-011 st_obst_xy  in  18  obstacle corners /100: obst1 X[17:15] Y[14:12], obst2 X[11:9] Y[8:6], obst3 X[5:3] Y[2:0].
REQ-012 btn_up, btn_down, btn_left, btn_right  in  1 each  synchronised, level-sensitive move requests.
REQ-013 hcount_out, vcount_out  out  11 each; hsync_out, hblank_out, vsync_out, vblank_out  out  1 each  delayed timing.
REQ-014 rgb_out  out  12  composited pixel.
REQ-015 player_x, player_y  out  11 each  committed top-left position.
REQ-016 at_door  out  1  player has reached the door area.

Function
REQ-017 All timing outputs SHALL equal their inputs delayed by exactly 1 pclk.
REQ-018 rgb_out SHALL be 1 pclk after inputs: PLAYER_RGB when no blank and player_x<=hcount_in<player_x+PLAYER_SIZE and player_y<=vcount_in<player_y+PLAYER_SIZE, else rgb_in.
REQ-019 FSM states: IDLE, CHK_X, CHK_Y, COMMIT, WON.
REQ-020 IDLE -> CHK_X on rising edge of vblank_in (registered previous vblank_in=0, current=1); exactly one update per frame.
REQ-021 At CHK_X entry, candidate x = player_x+STEP (right only), player_x-STEP (left only), else player_x; both left and right = no x move.
REQ-022 CHK_X SHALL last 3 cycles, testing obstacle 0,1,2 via 2-bit index; any hit or bound violation keeps x; then -> CHK_Y.
REQ-023 CHK_Y SHALL behave identically on y (down = +STEP, up = -STEP) using the x result from CHK_X; 3 cycles; then -> COMMIT.
REQ-024 Obstacle i hit: cx<100*Xi+100 and cx+PLAYER_SIZE>100*Xi and cy<100*Yi+100 and cy+PLAYER_SIZE>100*Yi; edge touching is not a hit.
REQ-025 Bounds: left allowed only if player_x>=1+STEP; up only if player_y>=1+STEP; right only if cx<=799-PLAYER_SIZE; down only if cy<=599-PLAYER_SIZE; no wrap-around.
REQ-026 Arithmetic SHALL be 12-bit unsigned to avoid overflow of x+PLAYER_SIZE+STEP.
REQ-027 COMMIT writes player_x/player_y in one cycle; -> WON if 710<=x, x+PLAYER_SIZE<=790, 250<=y, y+PLAYER_SIZE<=390, else -> IDLE.
REQ-028 WON is terminal until reset: at_door=1, position frozen, drawing continues.
REQ-029 Position SHALL change only in COMMIT, which occurs during vblank, so no frame shows a split player.
REQ-030 Button changes during CHK_X/CHK_Y SHALL be ignored; candidate direction is sampled at state entry.

Reset
REQ-031 On rst: all timing outputs 0, rgb_out 0, at_door 0, player_x=START_X, player_y=START_Y, FSM IDLE, vblank edge register 0.
REQ-032 rst mid-check SHALL abort the update; no partial position is committed.

Configuration
REQ-033 Macro DRAW_PLAYER_COLLISION_EN: defined -> obstacle tests of REQ-024 active; undefined -> only bound tests of REQ-025, st_obst_xy unused, CHK_X/CHK_Y timing unchanged (3 cycles each).

Verification
REQ-034 Reset, then idle frame -> player_x=20, player_y=500, at_door=0, rgb_out=12'h0F0 at pixel (25,505) with rgb_in=12'h888.
REQ-035 Start x=76,y=40, btn_right, obstacles 18'b001_000_010_001_011_010 -> after frame 1 x=80; after frame 2 x stays 80 (collision enabled), becomes 84 if macro undefined.
REQ-036 x=3, btn_left held 2 frames -> x stays 3; x=779 btn_right -> stays 779.
REQ-037 btn_left and btn_right together with btn_down, x=20,y=500 -> x=20, y=504 after one frame.
REQ-038 Drive player to x=720,y=300 -> at_door=1 after COMMIT; further button presses leave x/y unchanged.
REQ-039 Assert rst during CHK_Y -> next cycle position=START, FSM IDLE, outputs 0.
